// File: rtl/rom_boot_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// rom_boot_ctrl_pkg
//   Shared constants and types for the boot-load sequencer: frame start byte,
//   default address width / image depth, and the 3-bit FSM state encoding.
// -----------------------------------------------------------------------------
package rom_boot_ctrl_pkg;

  localparam logic [7:0]  BOOT_MAGIC = 8'hA5;  // frame start byte
  localparam int unsigned BOOT_AW    = 16;     // CPU word / address width
  localparam int unsigned BOOT_DEPTH = 1024;   // instruction RAM depth in words

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_D_HI   = 3'd3,
    ST_D_LO   = 3'd4,
    ST_CSUM   = 3'd5,
    ST_RUN    = 3'd6,
    ST_ERR    = 3'd7
  } boot_state_e;

  // A frame is "in progress" from the first length byte up to the checksum.
  function automatic logic is_busy(input boot_state_e s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_D_HI) ||
           (s == ST_D_LO)   || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/rom_boot_ctrl_if.sv
// -----------------------------------------------------------------------------
// rom_boot_ctrl_if
//   Byte-receive handshake plus ROM write port of the boot loader.
//   rx_valid/rx_data/rx_ready : byte stream, accepted when valid & ready
//   mem_we/mem_addr/mem_wdata : one-cycle ROM word write
//   slave  : the boot controller (consumes bytes, drives the ROM port)
//   master : the environment (byte receiver + ROM)
// -----------------------------------------------------------------------------
interface rom_boot_ctrl_if
  import rom_boot_ctrl_pkg::*;
#(
  parameter int AW = BOOT_AW
);

  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/rom_boot_ctrl_timer.sv
// -----------------------------------------------------------------------------
// rom_boot_ctrl_timer
//   Inter-byte watchdog: loadable down-counter. clr reloads it with TIMEOUT,
//   it counts down while en is high, and expire flags the cycle on which the
//   count would reach zero. TIMEOUT = 0 disables the watchdog.
//   clk, rst_n : clock, async active-low reset
//   en         : count enable (frame in progress)
//   clr        : reload (a byte was accepted)
//   expire     : idle budget used up this cycle
// -----------------------------------------------------------------------------
module rom_boot_ctrl_timer #(
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic expire
);

  if (TIMEOUT == 0) begin : g_off
    assign expire = 1'b0;
  end else begin : g_on
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
      end else if (clr) begin
        cnt <= TW'(TIMEOUT);
      end else if (en && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
    end

    // A byte on the expiry cycle reloads the counter and suppresses expire.
    assign expire = en && !clr && (cnt == TW'(1));
  end

endmodule

// File: rtl/rom_boot_ctrl.sv
// -----------------------------------------------------------------------------
// rom_boot_ctrl
//   Boot-load sequencer for the instruction ROM. Parses a framed byte stream
//   (MAGIC, 16-bit word length MSB first, payload, 8-bit checksum), packs
//   payload bytes big-endian into 16-bit words written at BASE+idx, and holds
//   the CPU in reset until the image's checksum verifies.
//   clk, rst_n : clock, async active-low reset (aborts a frame immediately)
//   bus        : byte handshake in, ROM write port out (slave modport)
//   reload     : pulse, leaves RUN/ERR back to IDLE
//   cpu_rst_n  : CPU reset, released only in RUN
//   busy       : frame in progress
//   done       : image loaded and verified
//   err        : frame rejected (bad length, checksum or timeout)
// -----------------------------------------------------------------------------
module rom_boot_ctrl
  import rom_boot_ctrl_pkg::*;
#(
  parameter logic [7:0]    MAGIC   = BOOT_MAGIC,
  parameter int            AW      = BOOT_AW,
  parameter int unsigned   DEPTH   = BOOT_DEPTH,
  parameter logic [AW-1:0] BASE    = '0,
  parameter int unsigned   TIMEOUT = 1000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rom_boot_ctrl_if.slave       bus,
  input  logic                 reload,
  output logic                 cpu_rst_n,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  boot_state_e state, state_n;
  logic [7:0]  hi_byte;
  logic [7:0]  len_hi;
  logic [15:0] len;
  logic [15:0] wcnt;
  logic [7:0]  sum;
  logic [15:0] len_in;
  logic [7:0]  csum_total;
  logic        fire;
  logic        expire;

  // The link is released while the CPU runs; every other state listens.
  assign bus.rx_ready = (state != ST_RUN);
  assign fire         = bus.rx_valid && bus.rx_ready;
  assign len_in       = {len_hi, bus.rx_data};
  assign csum_total   = sum + bus.rx_data;

  rom_boot_ctrl_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (busy),
    .clr    (fire),
    .expire (expire)
  );

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_n = state;
    case (state)
      ST_IDLE:   if (fire && (bus.rx_data == MAGIC)) state_n = ST_LEN_HI;
      ST_LEN_HI: if (fire) state_n = ST_LEN_LO;
      ST_LEN_LO: if (fire) begin
        if (32'(len_in) > DEPTH)  state_n = ST_ERR;
        else if (len_in == 16'd0) state_n = ST_CSUM;
        else                      state_n = ST_D_HI;
      end
      ST_D_HI:   if (fire) state_n = ST_D_LO;
      ST_D_LO:   if (fire) state_n = (wcnt == len - 16'd1) ? ST_CSUM : ST_D_HI;
      ST_CSUM:   if (fire) state_n = (csum_total == 8'h00) ? ST_RUN : ST_ERR;
      ST_RUN:    if (reload) state_n = ST_IDLE;
      ST_ERR: begin
        if (reload)                              state_n = ST_IDLE;
        else if (fire && (bus.rx_data == MAGIC)) state_n = ST_LEN_HI;
      end
      default:   state_n = ST_IDLE;
    endcase
    // Watchdog only fires on a byte-free cycle; an arriving byte wins.
    if (busy && !fire && expire) state_n = ST_ERR;
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: only control state is cleared; ROM contents written so far are
      // external and stay as they are.
      state         <= ST_IDLE;
      hi_byte       <= '0;
      len_hi        <= '0;
      len           <= '0;
      wcnt          <= '0;
      sum           <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= BASE;
      bus.mem_wdata <= '0;
      cpu_rst_n     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      state      <= state_n;
      bus.mem_we <= 1'b0;
      // Status outputs are registered from the next state so they change
      // glitch-free together with it.
      cpu_rst_n  <= (state_n == ST_RUN);
      done       <= (state_n == ST_RUN);
      err        <= (state_n == ST_ERR);
      busy       <= is_busy(state_n);
      if (fire) begin
        case (state)
          ST_IDLE, ST_ERR: begin
            // A possible frame start: clear per-frame accumulators.
            sum  <= '0;
            wcnt <= '0;
          end
          ST_LEN_HI: len_hi <= bus.rx_data;
          ST_LEN_LO: len    <= len_in;
          ST_D_HI: begin
            hi_byte <= bus.rx_data;
            sum     <= sum + bus.rx_data;
          end
          ST_D_LO: begin
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= BASE + AW'(wcnt);
            bus.mem_wdata <= {hi_byte, bus.rx_data};
            sum           <= sum + bus.rx_data;
            wcnt          <= wcnt + 16'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
